// File: rtl/pipeline_ifid_ctrl.sv
// IF/ID pipeline register with stall/flush control, event counters and a
// sticky back-to-back-stall hazard flag. One-edge latency, no extra buffering.
module pipeline_ifid_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_instr,
  output logic             pc_write,
  output logic             id_ex_bubble,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             hazard_err
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (c == {CNT_W{1'b1}}) ? c : c + CNT_ONE;
  endfunction

  state_t           state_p1;
  logic [31:0]      pc_p1;
  logic [31:0]      instr_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] stall_cnt_p1;
  logic [CNT_W-1:0] flush_cnt_p1;
  logic             hazard_err_p1;

  // Flush outranks stall, so a flush+stall cycle still advances the PC.
  assign pc_write     = ~(stall & ~flush);
  assign id_ex_bubble = stall | flush;

  // Stage p0 -> p1: IF/ID register and control state
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p1         <= 32'h0;
      instr_p1      <= NOP_INSTR;
      vld_p1        <= 1'b0;
      state_p1      <= RUN;
      stall_cnt_p1  <= '0;
      flush_cnt_p1  <= '0;
      hazard_err_p1 <= 1'b0;
    end else if (flush) begin
      pc_p1        <= if_pc;
      instr_p1     <= NOP_INSTR;
      vld_p1       <= 1'b0;
      state_p1     <= FLUSH;
      flush_cnt_p1 <= sat_inc(flush_cnt_p1);
    end else if (stall) begin
      // A stall while already stalled means the hazard unit requested a
      // second bubble for the same load; flag it but keep honouring it.
      if (state_p1 == STALL)
        hazard_err_p1 <= 1'b1;
      state_p1     <= STALL;
      stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end else begin
      pc_p1    <= if_pc;
      instr_p1 <= if_instr;
      vld_p1   <= 1'b1;
      state_p1 <= RUN;
    end
  end

  assign if_id_pc    = pc_p1;
  assign if_id_instr = instr_p1;
  assign if_id_valid = vld_p1;
  assign state       = state_p1;
  assign stall_cnt   = stall_cnt_p1;
  assign flush_cnt   = flush_cnt_p1;
  assign hazard_err  = hazard_err_p1;

endmodule

// File: tb/tb_pipeline_ifid_ctrl.sv
// Bench for pipeline_ifid_ctrl: directed scenarios followed by random
// stall/flush/reset traffic, all compared against a behavioural model.
module tb_pipeline_ifid_ctrl;

  localparam int          CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, stall, flush;
  logic [31:0]      if_pc, if_instr;
  logic             pc_write, id_ex_bubble;
  logic [31:0]      if_id_pc, if_id_instr;
  logic             if_id_valid;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             hazard_err;

  int checks = 0;
  int errors = 0;

  // Reference model: plain values, state as 0=RUN 1=STALL 2=FLUSH.
  logic [31:0] m_pc, m_instr;
  logic        m_valid, m_herr;
  int          m_state, m_sc, m_fc;

  always #5 clk = ~clk;

  pipeline_ifid_ctrl #(.NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_pc(if_pc), .if_instr(if_instr),
    .pc_write(pc_write), .id_ex_bubble(id_ex_bubble),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .hazard_err(hazard_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int inc_sat(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  // Drive one cycle, check combinational outputs, clock, then check registers.
  task automatic step(input logic r, input logic s, input logic f,
                      input logic [31:0] pc, input logic [31:0] ins);
    rst = r; stall = s; flush = f; if_pc = pc; if_instr = ins;
    #1;
    chk("pc_write", {31'b0, pc_write}, {31'b0, !(s && !f)});
    chk("id_ex_bubble", {31'b0, id_ex_bubble}, {31'b0, (s || f)});
    @(posedge clk);
    if (r) begin
      m_pc = 0; m_instr = NOP; m_valid = 0; m_state = 0;
      m_sc = 0; m_fc = 0; m_herr = 0;
    end else if (f) begin
      m_pc = pc; m_instr = NOP; m_valid = 0; m_state = 2; m_fc = inc_sat(m_fc);
    end else if (s) begin
      if (m_state == 1) m_herr = 1;
      m_state = 1; m_sc = inc_sat(m_sc);
    end else begin
      m_pc = pc; m_instr = ins; m_valid = 1; m_state = 0;
    end
    #1;
    chk("if_id_pc", if_id_pc, m_pc);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    chk("state", {30'b0, state}, m_state);
    chk("stall_cnt", {28'b0, stall_cnt}, m_sc);
    chk("flush_cnt", {28'b0, flush_cnt}, m_fc);
    chk("hazard_err", {31'b0, hazard_err}, {31'b0, m_herr});
  endtask

  initial begin
    // Normal flow
    step(1, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 32'h100, 32'h00A00093);
    chk("nf_pc", if_id_pc, 32'h100);
    chk("nf_instr", if_id_instr, 32'h00A00093);
    chk("nf_state", {30'b0, state}, 32'h0);

    // Load-use stall holds IF/ID
    step(0, 0, 0, 32'h104, 32'h0000A103);
    step(0, 1, 0, 32'h108, 32'h00000000);
    chk("lu_pc", if_id_pc, 32'h104);
    chk("lu_instr", if_id_instr, 32'h0000A103);
    chk("lu_state", {30'b0, state}, 32'h1);
    chk("lu_scnt", {28'b0, stall_cnt}, 32'h1);
    chk("lu_herr", {31'b0, hazard_err}, 32'h0);

    // Flush together with stall is a flush
    step(0, 1, 1, 32'h200, 32'h12345678);
    chk("fs_instr", if_id_instr, NOP);
    chk("fs_pc", if_id_pc, 32'h200);
    chk("fs_state", {30'b0, state}, 32'h2);
    chk("fs_fcnt", {28'b0, flush_cnt}, 32'h1);
    chk("fs_scnt", {28'b0, stall_cnt}, 32'h1);

    // Back-to-back stall sets the sticky hazard flag
    step(0, 1, 0, 32'h204, 32'h1);
    step(0, 1, 0, 32'h204, 32'h1);
    chk("hz_scnt", {28'b0, stall_cnt}, 32'h3);
    chk("hz_set", {31'b0, hazard_err}, 32'h1);
    step(0, 0, 0, 32'h204, 32'h2);
    step(0, 0, 0, 32'h208, 32'h3);
    chk("hz_sticky", {31'b0, hazard_err}, 32'h1);

    // Reset while stalled
    step(0, 1, 0, 32'h20C, 32'h4);
    step(1, 1, 0, 32'h210, 32'h5);
    chk("rs_state", {30'b0, state}, 32'h0);
    chk("rs_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rs_instr", if_id_instr, NOP);
    chk("rs_herr", {31'b0, hazard_err}, 32'h0);

    // Counter saturation
    for (int i = 0; i < 20; i++) step(0, 0, 1, 32'h300 + 4 * i, 32'h7);
    chk("sat_fcnt", {28'b0, flush_cnt}, 32'hF);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 32'h400, 32'h7);
    chk("sat_scnt", {28'b0, stall_cnt}, 32'hF);

    // Random traffic
    step(1, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 4) == 0, $urandom, $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
